ysyx_22040895_ifu_pf: RTL and testbench

Parametrised prefetching instruction-fetch unit that replaces the single-cycle fetch path of the NPC core. It issues in-order fetch requests to an instruction memory port over a valid/ready handshake, buffers up to DEPTH instructions with their PCs, and hands them to the IDU over a valid/ready handshake. On a jump/branch redirect from the CU/EXU it flushes the buffer and silently discards responses still in flight.

---
 rtl/ysyx_22040895_ifu_pf_pkg.sv | 13 +
 rtl/ysyx_22040895_pf_fifo.sv | 82 ++++++++
 rtl/ysyx_22040895_ifu_pf.sv | 91 +++++++++
 tb/tb_ysyx_22040895_ifu_pf.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_ifu_pf_pkg.sv
// Shared fetch-unit constants: default widths, buffer depth and boot PC.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ysyx_22040895_ifu_pf_pkg;

    localparam int unsigned YSYX_XLEN     = 64;
    localparam int unsigned YSYX_ILEN     = 32;
    localparam int unsigned YSYX_PF_DEPTH = 4;
    localparam logic [63:0] YSYX_RESET_PC = 64'h8000_0000;
    // Instructions are 4 bytes; the fetch PC advances by this amount.
    localparam int unsigned YSYX_INST_BYTES = 4;

endpackage

// File: rtl/ysyx_22040895_pf_fifo.sv
// Prefetch slot buffer: slots allocated at issue, filled in order by responses, popped by the IDU.
// Latency: a fill is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller guarantees allocation never exceeds DEPTH live slots.
module ysyx_22040895_pf_fifo
    import ysyx_22040895_ifu_pf_pkg::*;
#(
    parameter int unsigned XLEN  = YSYX_XLEN,
    parameter int unsigned ILEN  = YSYX_ILEN,
    parameter int unsigned DEPTH = YSYX_PF_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc_vld,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill_vld,
    input  logic [ILEN-1:0] fill_inst,
    input  logic            pop_vld,
    output logic            head_vld,
    output logic [ILEN-1:0] head_inst,
    output logic [XLEN-1:0] head_pc,
    output logic [PW-1:0]   alloc_cnt,
    output logic [PW-1:0]   pend_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            filled;
    } slot_t;

    slot_t         slots [DEPTH];
    logic [PW-1:0] wr;
    logic [PW-1:0] fl;
    logic [PW-1:0] rd;

    // Pointer bookkeeping; flush rewinds everything so the next fetch starts at slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr <= '0;
            fl <= '0;
            rd <= '0;
        end else if (flush) begin
            wr <= '0;
            fl <= '0;
            rd <= '0;
        end else begin
            if (alloc_vld) wr <= wr + PW'(1);
            if (fill_vld)  fl <= fl + PW'(1);
            if (pop_vld)   rd <= rd + PW'(1);
        end
    end

    // Slot contents; allocation and fill never target the same slot because fill needs wr != fl
    // and allocation is blocked while all DEPTH slots are in use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) slots[i].filled <= 1'b0;
        end else begin
            if (alloc_vld) begin
                slots[wr[AW-1:0]].pc     <= alloc_pc;
                slots[wr[AW-1:0]].filled <= 1'b0;
            end
            if (fill_vld) begin
                slots[fl[AW-1:0]].inst   <= fill_inst;
                slots[fl[AW-1:0]].filled <= 1'b1;
            end
        end
    end

    // Head is valid once its slot has been filled; outputs show slot[rd] even when empty.
    assign head_vld  = (rd != fl) && slots[rd[AW-1:0]].filled;
    assign head_inst = slots[rd[AW-1:0]].inst;
    assign head_pc   = slots[rd[AW-1:0]].pc;
    assign alloc_cnt = wr - rd;
    assign pend_cnt  = wr - fl;

endmodule

// File: rtl/ysyx_22040895_ifu_pf.sv
// Prefetching IFU: in-order fetch requests, DEPTH-slot buffer, redirect flush with stale-response drop.
// Latency: request issues the cycle after reset/redirect; a response is presented to the IDU one cycle later.
// Backpressure: issue stops when live slots plus stale responses reach DEPTH; IDU stalls hold the head.
module ysyx_22040895_ifu_pf
    import ysyx_22040895_ifu_pf_pkg::*;
#(
    parameter int unsigned     XLEN     = YSYX_XLEN,
    parameter int unsigned     ILEN     = YSYX_ILEN,
    parameter int unsigned     DEPTH    = YSYX_PF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(YSYX_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i_pf,
    input  logic [XLEN-1:0] dnpc_i_pf,
    output logic            req_valid_o_pf,
    input  logic            req_ready_i_pf,
    output logic [XLEN-1:0] req_addr_o_pf,
    input  logic            resp_valid_i_pf,
    input  logic [ILEN-1:0] resp_inst_i_pf,
    output logic            inst_valid_o_pf,
    input  logic            inst_ready_i_pf,
    output logic [ILEN-1:0] inst_o_pf,
    output logic [XLEN-1:0] pc_o_pf
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] fpc;
    logic [DW-1:0]   drop_cnt;
    logic [PW-1:0]   alloc_cnt;
    logic [PW-1:0]   pend_cnt;
    logic [CW-1:0]   credit_use;
    logic [DW-1:0]   drop_next;
    logic            head_vld;
    logic            req_fire;
    logic            resp_keep;
    logic            pop_fire;

    // Every in-flight request (live slot or stale response still to arrive) holds one credit.
    assign credit_use     = CW'(alloc_cnt) + CW'(drop_cnt);
    assign req_valid_o_pf = rst && !redirect_i_pf && (credit_use < CW'(DEPTH));
    assign req_addr_o_pf  = fpc;
    assign req_fire       = req_valid_o_pf && req_ready_i_pf;

    // Responses owed to pre-redirect requests are swallowed until drop_cnt drains.
    assign resp_keep = resp_valid_i_pf && (drop_cnt == '0) && !redirect_i_pf;
    assign pop_fire  = head_vld && inst_ready_i_pf;

    // On redirect, every unfilled request becomes stale, except one answered in this very cycle.
    assign drop_next = drop_cnt + DW'(pend_cnt) - DW'(resp_valid_i_pf);

    // Fetch PC and stale-response counter; redirect overrides normal issue and drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc      <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_i_pf) begin
            fpc      <= dnpc_i_pf & ~XLEN'(3);
            drop_cnt <= drop_next;
        end else begin
            if (req_fire) fpc <= fpc + XLEN'(YSYX_INST_BYTES);
            if (resp_valid_i_pf && (drop_cnt != '0)) drop_cnt <= drop_cnt - DW'(1);
        end
    end

    ysyx_22040895_pf_fifo #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i_pf),
        .alloc_vld (req_fire),
        .alloc_pc  (fpc),
        .fill_vld  (resp_keep),
        .fill_inst (resp_inst_i_pf),
        .pop_vld   (pop_fire),
        .head_vld  (head_vld),
        .head_inst (inst_o_pf),
        .head_pc   (pc_o_pf),
        .alloc_cnt (alloc_cnt),
        .pend_cnt  (pend_cnt)
    );

    assign inst_valid_o_pf = head_vld;

endmodule

// File: tb/tb_ysyx_22040895_ifu_pf.sv
// Testbench for the prefetching IFU: memory model with configurable latency plus an
// architectural model of the expected fetch/delivery PC streams.
// Stimulus is driven just after the rising edge, outputs are sampled on the falling edge.
module tb_ysyx_22040895_ifu_pf;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_i_pf;
    logic [63:0] dnpc_i_pf;
    logic        req_valid_o_pf;
    logic        req_ready_i_pf;
    logic [63:0] req_addr_o_pf;
    logic        resp_valid_i_pf;
    logic [31:0] resp_inst_i_pf;
    logic        inst_valid_o_pf;
    logic        inst_ready_i_pf;
    logic [31:0] inst_o_pf;
    logic [63:0] pc_o_pf;

    ysyx_22040895_ifu_pf #(
        .XLEN     (64),
        .ILEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_i_pf   (redirect_i_pf),
        .dnpc_i_pf       (dnpc_i_pf),
        .req_valid_o_pf  (req_valid_o_pf),
        .req_ready_i_pf  (req_ready_i_pf),
        .req_addr_o_pf   (req_addr_o_pf),
        .resp_valid_i_pf (resp_valid_i_pf),
        .resp_inst_i_pf  (resp_inst_i_pf),
        .inst_valid_o_pf (inst_valid_o_pf),
        .inst_ready_i_pf (inst_ready_i_pf),
        .inst_o_pf       (inst_o_pf),
        .pc_o_pf         (pc_o_pf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] dnpc;
        logic [63:0] exp_addr;
        logic        idu_rdy;
    } rvec_t;

    mreq_t       mq[$];
    int          cyc, lat, n_chk, n_err, n_acc, n_pop;
    logic        c_mem_rdy, c_idu_rdy, c_redir;
    logic [63:0] c_dnpc;
    logic [63:0] exp_pc, exp_req, last_acc;
    logic        s_req_vld, s_inst_vld, s_resp_vld;
    logic [63:0] s_req_addr, s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] mk_inst(logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, advance the reference model.
    task automatic cycle();
        resp_valid_i_pf = 1'b0;
        resp_inst_i_pf  = 32'hDEAD_BEEF;
        if (mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                resp_valid_i_pf = 1'b1;
                resp_inst_i_pf  = mk_inst(mq[0].addr);
            end
        end
        req_ready_i_pf  = c_mem_rdy;
        inst_ready_i_pf = c_idu_rdy;
        redirect_i_pf   = c_redir;
        dnpc_i_pf       = c_dnpc;
        @(negedge clk);
        s_req_vld  = req_valid_o_pf;
        s_req_addr = req_addr_o_pf;
        s_inst_vld = inst_valid_o_pf;
        s_pc       = pc_o_pf;
        s_inst     = inst_o_pf;
        s_resp_vld = resp_valid_i_pf;
        if (s_resp_vld) void'(mq.pop_front());
        if (s_inst_vld && c_idu_rdy) begin
            chk("pop_pc", s_pc, exp_pc);
            chk("pop_inst", 64'(s_inst), 64'(mk_inst(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            n_pop++;
        end
        if (c_redir) begin
            chk("redir_req_low", 64'(s_req_vld), 64'd0);
            exp_pc  = c_dnpc & ~64'h3;
            exp_req = exp_pc;
        end else if (s_req_vld && c_mem_rdy) begin
            chk("req_addr", s_req_addr, exp_req);
            mq.push_back('{s_req_addr, cyc + lat});
            last_acc = s_req_addr;
            exp_req  = exp_req + 64'd4;
            n_acc++;
        end
        chk("outstanding_le_depth", 64'(mq.size() <= DEPTH), 64'd1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(int n);
        rst     = 1'b0;
        c_redir = 1'b0;
        mq.delete();
        repeat (n) cycle();
        exp_pc  = RST_PC;
        exp_req = RST_PC;
        rst     = 1'b1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_vld"},  64'(req_valid_o_pf),  64'd0);
        chk({tag, "_req_addr"}, req_addr_o_pf,        RST_PC);
        chk({tag, "_inst_vld"}, 64'(inst_valid_o_pf), 64'd0);
        chk({tag, "_inst"},     64'(inst_o_pf),       64'd0);
        chk({tag, "_pc"},       pc_o_pf,              64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rvec_t tv [5];
        int    k;
        logic  found;
        int    exp_drop;

        tv[0] = '{64'h0000_0000_8000_0006, 64'h0000_0000_8000_0004, 1'b1};
        tv[1] = '{64'h0000_0000_8000_1000, 64'h0000_0000_8000_1000, 1'b0};
        tv[2] = '{64'h0000_0001_2345_6783, 64'h0000_0001_2345_6780, 1'b1};
        tv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tv[4] = '{64'h0000_0000_0000_0002, 64'h0000_0000_0000_0000, 1'b1};

        n_chk = 0; n_err = 0; n_acc = 0; n_pop = 0; cyc = 0; lat = 1;
        c_mem_rdy = 1'b1; c_idu_rdy = 1'b1; c_redir = 1'b0; c_dnpc = '0;
        exp_pc = RST_PC; exp_req = RST_PC; last_acc = '0;
        redirect_i_pf = 1'b0; dnpc_i_pf = '0; req_ready_i_pf = 1'b0;
        resp_valid_i_pf = 1'b0; resp_inst_i_pf = '0; inst_ready_i_pf = 1'b0;

        // Reset values while rst is held low.
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_reset_outputs("rst");
        @(posedge clk);
        #1;

        // Latency 1, everything ready: first request at boot PC, first delivery two cycles later.
        lat = 1; c_mem_rdy = 1'b1; c_idu_rdy = 1'b1;
        do_reset(2);
        cycle();
        chk("t1_first_req_vld",  64'(s_req_vld), 64'd1);
        chk("t1_first_req_addr", s_req_addr,     RST_PC);
        cycle();
        chk("t1_c1_inst_vld", 64'(s_inst_vld), 64'd0);
        cycle();
        chk("t1_c2_inst_vld", 64'(s_inst_vld), 64'd1);
        chk("t1_c2_pc",       s_pc,            RST_PC);
        k = 0;
        repeat (8) begin
            cycle();
            if (s_inst_vld) k++;
        end
        chk("t1_rate", 64'(k), 64'd8);

        // IDU stalled: exactly DEPTH requests, then nothing until a pop frees a slot.
        c_idu_rdy = 1'b0;
        n_acc = 0;
        do_reset(2);
        repeat (10) cycle();
        chk("t2_accepts",  64'(n_acc), 64'd4);
        chk("t2_last_req", last_acc,   RST_PC + 64'd12);
        chk("t2_req_low",  64'(s_req_vld), 64'd0);
        c_idu_rdy = 1'b1;
        n_pop = 0;
        repeat (4) cycle();
        chk("t2_pops", 64'(n_pop), 64'd4);

        // Latency 3, redirect with two requests outstanding.
        lat = 3;
        do_reset(2);
        cycle();
        cycle();
        c_redir = 1'b1; c_dnpc = 64'h8000_1000;
        cycle();
        c_redir = 1'b0;
        chk("t3_drop_cnt", 64'(dut.drop_cnt), 64'd2);
        cycle();
        chk("t3_next_req_vld",  64'(s_req_vld), 64'd1);
        chk("t3_next_req_addr", s_req_addr,     64'h8000_1000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_inst_vld) begin
                found = 1'b1;
                chk("t3_first_pc", s_pc, 64'h8000_1000);
            end
        end
        chk("t3_first_seen", 64'(found), 64'd1);

        // Redirect in a cycle that also carries a response and a pop.
        repeat (10) cycle();
        found = 1'b0;
        exp_drop = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc && inst_valid_o_pf) begin
                found    = 1'b1;
                exp_drop = mq.size() - 1;
                c_redir  = 1'b1;
                c_dnpc   = 64'h8000_2000;
            end
            cycle();
            if (found) begin
                c_redir = 1'b0;
                chk("t4_pop_in_redirect", 64'(s_inst_vld), 64'd1);
                chk("t4_drop_cnt", 64'(dut.drop_cnt), 64'(exp_drop));
            end
        end
        chk("t4_found", 64'(found), 64'd1);
        repeat (15) cycle();

        // Table of redirect targets: alignment and restart address.
        lat = 1; c_mem_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_idu_rdy = tv[i].idu_rdy;
            repeat (6) cycle();
            c_redir = 1'b1; c_dnpc = tv[i].dnpc;
            cycle();
            chk("tv_redir_req_low", 64'(s_req_vld), 64'd0);
            c_redir = 1'b0;
            cycle();
            chk("tv_next_req_vld",  64'(s_req_vld), 64'd1);
            chk("tv_next_req_addr", s_req_addr,     tv[i].exp_addr);
        end

        // Asynchronous reset mid-stream with three requests outstanding.
        lat = 3; c_idu_rdy = 1'b1; c_mem_rdy = 1'b1; c_redir = 1'b0;
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() == 3) found = 1'b1;
            else cycle();
        end
        chk("t6_three_outstanding", 64'(found), 64'd1);
        #2 rst = 1'b0;
        resp_valid_i_pf = 1'b0;
        mq.delete();
        #1 chk_reset_outputs("t6");
        @(posedge clk);
        #1;
        cyc++;
        do_reset(2);
        cycle();
        chk("t6_restart_req_vld",  64'(s_req_vld),  64'd1);
        chk("t6_restart_req_addr", s_req_addr,      RST_PC);
        chk("t6_restart_inst_vld", 64'(s_inst_vld), 64'd0);
        repeat (10) cycle();

        // Randomized traffic against the reference model.
        do_reset(2);
        for (int ph = 0; ph < 6; ph++) begin
            lat = $urandom_range(1, 5);
            repeat (100) begin
                c_mem_rdy = ($urandom_range(0, 3) != 0);
                c_idu_rdy = ($urandom_range(0, 2) != 0);
                c_redir   = ($urandom_range(0, 19) == 0);
                c_dnpc    = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF))};
                cycle();
            end
        end
        c_redir = 1'b0; c_mem_rdy = 1'b1; c_idu_rdy = 1'b1;
        n_pop = 0;
        repeat (40) cycle();
        chk("drain_progress", 64'(n_pop >= 10), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
